fnd_scan_ctrl: RTL



---
 rtl/fnd_scan_ctrl.sv | 119 +++++++++++
 1 files changed

// File: rtl/fnd_scan_ctrl.sv
// Multiplexed 7-segment scan controller: double-buffered BCD word, one digit lit per slot.
// Optional leading-zero blanking is built when FND_SCAN_BLANK_EN is defined.
module fnd_scan_ctrl #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    output logic [3:0]            bcd,
    output logic [DIGITS-1:0]     dig_sel,
    output logic [2:0]            dig_idx,
    output logic                  frame_done
);

    localparam int                CNT_W   = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(SCAN_DIV - 1);
    localparam logic [2:0]        IDX_MAX = 3'(DIGITS - 1);

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2:0]          idx_q, idx_d;
    logic [4*DIGITS-1:0] staging_q, staging_d;
    logic [4*DIGITS-1:0] display_q, display_d;
    logic                pending_q, pending_d;
    logic [3:0]          bcd_q, bcd_d;
    logic [DIGITS-1:0]   dig_sel_q, dig_sel_d;
    logic                frame_done_q, frame_done_d;
    logic                tick, wrap;
    logic [DIGITS-1:0]   lit_mask;

    always_comb begin
        tick         = en && (cnt_q == CNT_MAX);
        wrap         = tick && (idx_q == IDX_MAX);
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        staging_d    = staging_q;
        display_d    = display_q;
        pending_d    = pending_q;
        frame_done_d = wrap;

        if (en) begin
            cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        end
        if (tick) begin
            idx_d = wrap ? 3'd0 : idx_q + 3'd1;
        end

        if (load) begin
            staging_d = value;
            pending_d = 1'b1;
        end
        // Commit only at a frame boundary while scanning; a dark display can take it at once.
        if (wrap && (pending_q || load)) begin
            display_d = load ? value : staging_q;
            pending_d = 1'b0;
        end else if (!en && load) begin
            display_d = value;
            pending_d = 1'b0;
        end
    end

`ifdef FND_SCAN_BLANK_EN
    always_comb begin : blank_p
        logic zero_above;
        zero_above  = 1'b1;
        lit_mask    = '1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_above  = zero_above && (display_d[4*i +: 4] == 4'd0);
            lit_mask[i] = !zero_above;
        end
    end
`else
    assign lit_mask = '1;
`endif

    // Outputs are computed from next-state so they step on the same edge as idx.
    always_comb begin
        bcd_d     = 4'd0;
        dig_sel_d = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_d == 3'(i)) begin
                bcd_d = display_d[4*i +: 4];
                if (en && lit_mask[i]) begin
                    dig_sel_d[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= 3'd0;
            staging_q    <= '0;
            display_q    <= '0;
            pending_q    <= 1'b0;
            bcd_q        <= 4'd0;
            dig_sel_q    <= '1;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            staging_q    <= staging_d;
            display_q    <= display_d;
            pending_q    <= pending_d;
            bcd_q        <= bcd_d;
            dig_sel_q    <= dig_sel_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bcd        = bcd_q;
    assign dig_sel    = dig_sel_q;
    assign dig_idx    = idx_q;
    assign frame_done = frame_done_q;

endmodule
